game_input_router: RTL and testbench
====================================

# game_input_router

Input-side counterpart of the game output selector. Synchronizes and debounces raw `KEY[3:0]` pushbuttons and `SW[9:0]` switches. Turns each debounced press into a single-cycle command strobe routed only to the currently selected game (roulette, even/odd roulette, blackjack). While a game is in progress, the block holds the game mode and the player's guess so that switch movement cannot corrupt a running game.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key change is accepted (10 ms at 50 MHz); benches override it to 4.

Ports:
- `CLOCK_50`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `KEY`  in  4  raw pushbuttons, active-low (pressed = 0), asynchronous to the clock.
- `SW`  in  10  raw switches, asynchronous; `SW[9:8]` selects the mode, `SW[4:0]` is the guess.
- `mode`  out  2  latched game mode; 00 = roulette, 01 = even/odd, 11 = blackjack, 10 = none.
- `active`  out  1  high while a game is in progress (ACTIVE state).
- `mode_pending`  out  1  high while ACTIVE and the synchronized `SW[9:8]` differs from `mode`.
- `guess`  out  5  player guess, latched at the spin strobe.
- `game_clr`  out  1  one-cycle strobe on a `KEY[1]` press, in every mode.
- `rl_spin`  out  1  one-cycle strobe on a `KEY[2]` press when mode is 00.
- `eo_spin`  out  1  one-cycle strobe on a `KEY[2]` press when mode is 01.
- `bj_pass`  out  1  one-cycle strobe on a `KEY[2]` press when mode is 11.
- `bj_enter`  out  1  one-cycle strobe on a `KEY[3]` press when mode is 11.

## Operation
- **Reset values:** all outputs are 0, `mode` is 00, the FSM is in IDLE, and the debounced key state is 1 (released).
- **Per-key path:**
  - A 2-flop synchronizer feeds a counter.
  - The counter increments every cycle that the synchronized value differs from the stable value, and clears to 0 on any cycle where they match.
  - The stable value flips when the counter reaches `DEBOUNCE_CYCLES`.
  - A 1→0 transition of the stable value produces a one-cycle press pulse.
  - Releases produce no pulse. Holding a key produces exactly one pulse.
- **Switch path:** `SW[9:8]` and `SW[4:0]` each pass through a 2-flop synchronizer. Switches are not debounced.
- **FSM states:** IDLE and ACTIVE.
  - IDLE: `mode` follows synchronized `SW[9:8]` every cycle. Any routed `rl_spin`/`eo_spin`/`bj_enter`/`bj_pass` moves the FSM to ACTIVE.
  - ACTIVE: `mode` is frozen. A `KEY[1]` press issues `game_clr` and returns the FSM to IDLE.
- **Guess latch:** `guess` loads synchronized `SW[4:0]` in the same cycle that `rl_spin` or `eo_spin` is issued. It is unchanged otherwise, and does not load on `bj_enter` or `bj_pass`.
- **Mode 10:** key presses produce no game strobes and the FSM stays in IDLE; `game_clr` is still issued.
- **Simultaneous presses:**
  - A `KEY[1]` press in the same cycle as any other press: only `game_clr` is issued, and the other press is dropped.
  - `KEY[2]` and `KEY[3]` pressed in the same cycle in blackjack: only `bj_enter` is issued.
- **Mode change mid-game:** the switch change is ignored and `mode_pending` is raised. After the next `game_clr`, the new mode is adopted on the first IDLE cycle.
- **Bounce:** a synchronized glitch shorter than `DEBOUNCE_CYCLES` cycles resets the counter and produces no pulse.
- **Asynchronous reset mid-game:** clears everything to the reset values immediately, including discarding any in-flight debounce count.

## Timing
- Edge 1 is the first rising edge after `KEY[n]` falls:
  - the synchronized value changes at edge 2;
  - the stable value flips at edge 2+`DEBOUNCE_CYCLES`;
  - the strobe is registered high from edge 3+`DEBOUNCE_CYCLES` for exactly one cycle.
- `active`, `mode` freeze and `guess` all update on the same edge the strobe rises.
- `SW` to `mode` latency in IDLE is 3 edges (2 synchronizer stages plus the register).
- Strobes are never high for two consecutive cycles from a single press.

## Structure
- Shared package `game_pkg` holds:
  - the mode constants `MODE_ROULETTE=2'b00`, `MODE_EVENODD=2'b01`, `MODE_BLACKJACK=2'b11`;
  - the IDLE/ACTIVE state encoding;
  - the 5-bit guess width.
- One sub-module, `key_debounce`, contains the synchronizer, counter, stable register and press pulse. It is instantiated 4 times, once per key.
- Routing, priority, the FSM and the latches live in the top level.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset, then hold `SW[9:8]`=11 and press `KEY[3]` cleanly → `bj_enter` high at exactly edge 7 for 1 cycle; `active`=1; no other strobe fires.
- `SW[9:8]`=00, `SW[4:0]`=10110, then press `KEY[2]` → `rl_spin` pulses once; `guess`=10110. Then change `SW[4:0]` to 00001 → `guess` stays 10110.
- In blackjack, toggle `KEY[3]` low for 3 cycles, high for 1, repeatedly, then hold it low → no strobe during the bouncing; exactly one `bj_enter` once the key has been held steady.
- While ACTIVE in mode 01, flip `SW[9:8]` to 11 → `mode` stays 01 and `mode_pending`=1. Press `KEY[1]` → `game_clr` pulses once; `mode`=11 three edges later; `mode_pending`=0.
- In blackjack, press `KEY[1]`, `KEY[2]` and `KEY[3]` with identical timing → only `game_clr`. Repeat with only `KEY[2]` and `KEY[3]` → only `bj_enter`.
- Assert `reset_n`=0 asynchronously mid-debounce while ACTIVE → all outputs 0 before the next edge; releasing reset with the key still held low → no strobe until `DEBOUNCE_CYCLES` plus synchronizer delay has elapsed.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants and types for the game input path: mode codes,
// FSM state encoding, guess width and the debug view of the router.
package game_pkg;

  localparam logic [1:0] MODE_ROULETTE  = 2'b00;
  localparam logic [1:0] MODE_EVENODD   = 2'b01;
  localparam logic [1:0] MODE_NONE      = 2'b10;
  localparam logic [1:0] MODE_BLACKJACK = 2'b11;

  localparam int GUESS_W = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [3:0] key_press;
    logic [9:0] sw_sync;
  } game_dbg_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle pulse on each debounced press (active-low key).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // The counter reaching its last value on a differing cycle is the
  // DEBOUNCE_CYCLES-th consecutive mismatch, so the level flips there.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_input_router.sv
// Debounces the keys, synchronizes the switches and routes each press as a
// one-cycle command to the selected game; mode is frozen while a game runs.
module game_input_router
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [3:0]         KEY,
  input  logic [9:0]         SW,
  output logic [1:0]         mode,
  output logic               active,
  output logic               mode_pending,
  output logic [GUESS_W-1:0] guess,
  output logic               game_clr,
  output logic               rl_spin,
  output logic               eo_spin,
  output logic               bj_pass,
  output logic               bj_enter,
  output game_dbg_t          dbg_o
);

  logic [3:0] key_press;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk_i   (CLOCK_50),
      .rst_ni  (reset_n),
      .key_i   (KEY[k]),
      .press_o (key_press[k])
    );
  end

  logic [9:0]         sw1_q, sw2_q;
  state_t             state_q;
  logic [1:0]         mode_q;
  logic [GUESS_W-1:0] guess_q;
  logic               clr_q, rl_q, eo_q, pass_q, enter_q;
  logic               clr_d, rl_d, eo_d, pass_d, enter_d, go_d;

  // KEY[1] wins over every other press; KEY[3] wins over KEY[2] in blackjack.
  always_comb begin
    clr_d   = key_press[1];
    rl_d    = 1'b0;
    eo_d    = 1'b0;
    pass_d  = 1'b0;
    enter_d = 1'b0;
    if (!key_press[1]) begin
      case (mode_q)
        MODE_ROULETTE:  rl_d = key_press[2];
        MODE_EVENODD:   eo_d = key_press[2];
        MODE_BLACKJACK: begin
          enter_d = key_press[3];
          pass_d  = key_press[2] & ~key_press[3];
        end
        default: ;
      endcase
    end
    go_d = rl_d | eo_d | pass_d | enter_d;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sw1_q   <= '0;
      sw2_q   <= '0;
      state_q <= ST_IDLE;
      mode_q  <= MODE_ROULETTE;
      guess_q <= '0;
      clr_q   <= 1'b0;
      rl_q    <= 1'b0;
      eo_q    <= 1'b0;
      pass_q  <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      sw1_q   <= SW;
      sw2_q   <= sw1_q;
      clr_q   <= clr_d;
      rl_q    <= rl_d;
      eo_q    <= eo_d;
      pass_q  <= pass_d;
      enter_q <= enter_d;
      if (rl_d || eo_d) guess_q <= sw2_q[GUESS_W-1:0];
      case (state_q)
        ST_IDLE: begin
          // Hold the mode on the starting edge so it matches the issued strobe.
          if (go_d) state_q <= ST_ACTIVE;
          else      mode_q  <= sw2_q[9:8];
        end
        ST_ACTIVE: begin
          if (clr_d) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode         = mode_q;
  assign active       = (state_q == ST_ACTIVE);
  assign mode_pending = active && (sw2_q[9:8] != mode_q);
  assign guess        = guess_q;
  assign game_clr     = clr_q;
  assign rl_spin      = rl_q;
  assign eo_spin      = eo_q;
  assign bj_pass      = pass_q;
  assign bj_enter     = enter_q;
  assign dbg_o        = '{state: state_q, key_press: key_press, sw_sync: sw2_q};

endmodule

// File: tb/tb_game_input_router.sv
// Bench for game_input_router: directed table, multi-cycle corner sequences
// and random key/switch activity checked against a sample-history model.
module tb_game_input_router;
  import game_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic [9:0] SW = '0;
  logic [1:0] mode;
  logic       active, mode_pending, game_clr, rl_spin, eo_spin, bj_pass, bj_enter;
  logic [4:0] guess;
  game_dbg_t  dbg;

  always #5 clk = ~clk;

  game_input_router #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .KEY(KEY), .SW(SW),
    .mode(mode), .active(active), .mode_pending(mode_pending), .guess(guess),
    .game_clr(game_clr), .rl_spin(rl_spin), .eo_spin(eo_spin),
    .bj_pass(bj_pass), .bj_enter(bj_enter), .dbg_o(dbg)
  );

  // Reference model: raw samples are kept per edge; a key's level flips when
  // the D samples seen through the 2-stage synchronizer all disagree with it
  // and at least D edges have passed since its previous flip.
  logic [3:0] kh [0:DB+1];
  logic [9:0] swh [0:2];
  logic [3:0] m_stable = 4'hF;
  logic [3:0] pend = 4'h0;
  int         since [4];
  logic [1:0] e_mode = 2'b00;
  logic       e_active = 1'b0, e_pend = 1'b0;
  logic [4:0] e_guess = '0;
  logic       e_clr = 1'b0, e_rl = 1'b0, e_eo = 1'b0, e_pass = 1'b0, e_enter = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= DB + 1; j++) kh[j] = 4'hF;
      for (int j = 0; j < 3; j++) swh[j] = '0;
      for (int k = 0; k < 4; k++) since[k] = DB;
      m_stable = 4'hF; pend = 4'h0;
      e_mode = 2'b00; e_active = 1'b0; e_pend = 1'b0; e_guess = '0;
      e_clr = 1'b0; e_rl = 1'b0; e_eo = 1'b0; e_pass = 1'b0; e_enter = 1'b0;
    end else begin
      e_clr = pend[1];
      e_rl = 1'b0; e_eo = 1'b0; e_pass = 1'b0; e_enter = 1'b0;
      if (!pend[1]) begin
        e_rl    = pend[2] && (e_mode == 2'b00);
        e_eo    = pend[2] && (e_mode == 2'b01);
        e_enter = pend[3] && (e_mode == 2'b11);
        e_pass  = pend[2] && !pend[3] && (e_mode == 2'b11);
      end
      if (e_rl || e_eo) e_guess = swh[1][4:0];
      if (!e_active) begin
        if (e_rl || e_eo || e_pass || e_enter) e_active = 1'b1;
        else e_mode = swh[1][9:8];
      end else if (e_clr) begin
        e_active = 1'b0;
      end
      swh[2] = swh[1]; swh[1] = swh[0]; swh[0] = SW;
      for (int j = DB + 1; j > 0; j--) kh[j] = kh[j-1];
      kh[0] = KEY;
      e_pend = e_active && (swh[1][9:8] != e_mode);
      for (int k = 0; k < 4; k++) begin
        logic flip;
        if (since[k] < DB) since[k]++;
        flip = (since[k] >= DB);
        for (int j = 2; j <= DB + 1; j++) if (kh[j][k] == m_stable[k]) flip = 1'b0;
        pend[k] = 1'b0;
        if (flip) begin
          m_stable[k] = kh[2][k];
          since[k] = 0;
          pend[k] = ~kh[2][k];
        end
      end
    end
  end

  int n_vec = 0, n_bad = 0;
  int c_clr, c_rl, c_eo, c_pass, c_enter;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model;
    check("m_mode", 32'(mode), 32'(e_mode));
    check("m_active", 32'(active), 32'(e_active));
    check("m_dbg_state", 32'(dbg.state == ST_ACTIVE), 32'(e_active));
    check("m_pending", 32'(mode_pending), 32'(e_pend));
    check("m_guess", 32'(guess), 32'(e_guess));
    check("m_strobes", 32'({game_clr, rl_spin, eo_spin, bj_pass, bj_enter}),
          32'({e_clr, e_rl, e_eo, e_pass, e_enter}));
  endtask

  task automatic clear_counts;
    c_clr = 0; c_rl = 0; c_eo = 0; c_pass = 0; c_enter = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    check_model();
    if (game_clr) c_clr++;
    if (rl_spin)  c_rl++;
    if (eo_spin)  c_eo++;
    if (bj_pass)  c_pass++;
    if (bj_enter) c_enter++;
  endtask

  task automatic press_keys(input logic [3:0] mask, input int hold);
    KEY = ~mask;
    repeat (hold) tick();
    KEY = 4'hF;
    repeat (DB + 8) tick();
  endtask

  typedef struct {
    logic [1:0] swm;
    logic [4:0] swg;
    logic [3:0] keys;
    int         hold;
    int         x_clr, x_rl, x_eo, x_pass, x_enter;
    logic       x_act;
    logic [1:0] x_mode;
    logic [4:0] x_guess;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{2'b00, 5'b10110, 4'b0100, 8, 0, 1, 0, 0, 0, 1'b1, 2'b00, 5'b10110};
    tbl[1]  = '{2'b00, 5'b00001, 4'b0000, 0, 0, 0, 0, 0, 0, 1'b1, 2'b00, 5'b10110};
    tbl[2]  = '{2'b00, 5'b00001, 4'b0010, 8, 1, 0, 0, 0, 0, 1'b0, 2'b00, 5'b10110};
    tbl[3]  = '{2'b01, 5'b00111, 4'b0100, 8, 0, 0, 1, 0, 0, 1'b1, 2'b01, 5'b00111};
    tbl[4]  = '{2'b01, 5'b00111, 4'b0010, 8, 1, 0, 0, 0, 0, 1'b0, 2'b01, 5'b00111};
    tbl[5]  = '{2'b11, 5'b11111, 4'b0100, 8, 0, 0, 0, 1, 0, 1'b1, 2'b11, 5'b00111};
    tbl[6]  = '{2'b11, 5'b11111, 4'b1110, 8, 1, 0, 0, 0, 0, 1'b0, 2'b11, 5'b00111};
    tbl[7]  = '{2'b11, 5'b11111, 4'b1100, 8, 0, 0, 0, 0, 1, 1'b1, 2'b11, 5'b00111};
    tbl[8]  = '{2'b11, 5'b11111, 4'b0010, 8, 1, 0, 0, 0, 0, 1'b0, 2'b11, 5'b00111};
    tbl[9]  = '{2'b10, 5'b11111, 4'b0100, 8, 0, 0, 0, 0, 0, 1'b0, 2'b10, 5'b00111};
    tbl[10] = '{2'b10, 5'b11111, 4'b1000, 8, 0, 0, 0, 0, 0, 1'b0, 2'b10, 5'b00111};
    tbl[11] = '{2'b10, 5'b11111, 4'b0010, 8, 1, 0, 0, 0, 0, 1'b0, 2'b10, 5'b00111};
    tbl[12] = '{2'b00, 5'b11111, 4'b1000, 8, 0, 0, 0, 0, 0, 1'b0, 2'b00, 5'b00111};
    tbl[13] = '{2'b00, 5'b11111, 4'b0001, 8, 0, 0, 0, 0, 0, 1'b0, 2'b00, 5'b00111};

    clear_counts();
    repeat (3) tick();
    check("rst_mode", 32'(mode), 32'(2'b00));
    check("rst_active", 32'(active), 0);
    check("rst_guess", 32'(guess), 0);
    check("rst_strobes", 32'({game_clr, rl_spin, eo_spin, bj_pass, bj_enter, mode_pending}), 0);
    reset_n = 1'b1;

    // Clean KEY[3] press in blackjack: bj_enter exactly at edge 7.
    SW = 10'b11_000_00000;
    repeat (4) tick();
    KEY[3] = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check("A_bj_enter", 32'(bj_enter), 32'(e == 7));
      check("A_active", 32'(active), 32'(e >= 7));
      check("A_others", 32'({game_clr, rl_spin, eo_spin, bj_pass}), 0);
    end
    KEY = 4'hF;
    repeat (DB + 8) tick();
    press_keys(4'b0010, 8);

    foreach (tbl[i]) begin
      SW = {tbl[i].swm, 3'b000, tbl[i].swg};
      repeat (4) tick();
      clear_counts();
      press_keys(tbl[i].keys, tbl[i].hold);
      check($sformatf("T%0d_counts", i), 32'({c_clr[3:0], c_rl[3:0], c_eo[3:0], c_pass[3:0], c_enter[3:0]}),
            32'({tbl[i].x_clr[3:0], tbl[i].x_rl[3:0], tbl[i].x_eo[3:0], tbl[i].x_pass[3:0], tbl[i].x_enter[3:0]}));
      check($sformatf("T%0d_active", i), 32'(active), 32'(tbl[i].x_act));
      check($sformatf("T%0d_mode", i), 32'(mode), 32'(tbl[i].x_mode));
      check($sformatf("T%0d_guess", i), 32'(guess), 32'(tbl[i].x_guess));
    end

    // Bouncing KEY[3]: 3 low, 1 high, repeated; then held steady.
    SW = 10'b11_000_00000;
    repeat (4) tick();
    clear_counts();
    repeat (5) begin
      KEY[3] = 1'b0; repeat (3) tick();
      KEY[3] = 1'b1; tick();
    end
    check("B_bounce_quiet", 32'(c_enter), 0);
    KEY[3] = 1'b0; repeat (10) tick();
    KEY = 4'hF; repeat (DB + 8) tick();
    check("B_one_enter", 32'(c_enter), 1);
    check("B_active", 32'(active), 1);
    press_keys(4'b0010, 8);

    // Mode change mid-game is deferred until after game_clr.
    SW = 10'b01_000_00011;
    repeat (4) tick();
    press_keys(4'b0100, 8);
    SW[9:8] = 2'b11;
    repeat (5) tick();
    check("C_mode_frozen", 32'(mode), 32'(2'b01));
    check("C_pending", 32'(mode_pending), 1);
    begin
      logic found;
      found = 1'b0;
      clear_counts();
      KEY[1] = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        tick();
        if (game_clr) found = 1'b1;
      end
      check("C_clr_seen", 32'(found), 1);
      KEY = 4'hF;
      repeat (3) tick();
      check("C_mode_new", 32'(mode), 32'(2'b11));
      check("C_pending_off", 32'(mode_pending), 0);
      repeat (10) tick();
      check("C_one_clr", 32'(c_clr), 1);
    end

    // Async reset mid-debounce while a game is active.
    press_keys(4'b1000, 8);
    KEY[2] = 1'b0;
    repeat (3) tick();
    #3 reset_n = 1'b0;
    #1;
    check("D_rst_mode", 32'(mode), 0);
    check("D_rst_active", 32'(active), 0);
    check("D_rst_guess", 32'(guess), 0);
    check("D_rst_outs", 32'({game_clr, rl_spin, eo_spin, bj_pass, bj_enter, mode_pending}), 0);
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("D_bj_pass", 32'(bj_pass), 32'(e == 7));
      check("D_others", 32'({game_clr, rl_spin, eo_spin, bj_enter}), 0);
    end
    KEY = 4'hF;
    repeat (DB + 8) tick();

    // Random keys, switches and occasional resets against the model.
    for (int it = 0; it < 1200; it++) begin
      if ($urandom_range(0, 3) == 0) SW = 10'($urandom_range(0, 1023));
      KEY = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 9)) tick();
      if ($urandom_range(0, 3) == 0) SW[9:8] = 2'($urandom_range(0, 3));
      KEY = 4'hF;
      repeat ($urandom_range(1, 7)) tick();
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
